// File: rtl/sa_result_drain.sv
// Buffers whole result vectors from the systolic array and serializes them one 32-bit word per beat.
// Optional SA_DRAIN_STATS_EN adds a 16-bit captured-vector counter on port vcount.
module sa_result_drain #(
    parameter int ROWS  = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [31:0]             routport [0:ROWS-1],
    input  logic [0:ROWS-1]         rvalidport,
    output logic                    outread,
    output logic [31:0]             dout,
    output logic [$clog2(ROWS)-1:0] didx,
    output logic                    dlast,
    output logic                    dvalid,
    input  logic                    dready
`ifdef SA_DRAIN_STATS_EN
    ,
    output logic [15:0]             vcount
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int IW = $clog2(ROWS);

    localparam logic [PW-1:0] P_ONE    = PW'(1);
    localparam logic [CW-1:0] C_ONE    = CW'(1);
    localparam logic [CW-1:0] C_DEPTH  = CW'(DEPTH);
    localparam logic [IW-1:0] I_ONE    = IW'(1);
    localparam logic [IW-1:0] I_LAST   = IW'(ROWS - 1);

    logic [31:0]   mem [0:DEPTH-1][0:ROWS-1];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          capture;
    logic          beat;
    logic          pop;

    // Handshakes: a word moves downstream on any edge where dvalid && dready; a
    // vector moves in from the array on any edge where outread && all rvalidport bits.
    // Outputs are gated with rstn so nothing is offered while reset is asserted.
    assign outread = rstn && (count < C_DEPTH);
    assign dvalid  = rstn && (count != '0);
    assign dlast   = dvalid && (didx == I_LAST);
    assign dout    = mem[rd_ptr][didx];

    assign capture = outread && (&rvalidport);
    assign beat    = dvalid && dready;
    assign pop     = beat && (didx == I_LAST);

    // Storage is not reset; stale contents are unreachable once count is cleared.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int r = 0; r < ROWS; r++) begin
                mem[wr_ptr][r] <= routport[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            didx   <= '0;
        end else begin
            if (capture) begin
                wr_ptr <= wr_ptr + P_ONE;
            end
            if (beat) begin
                didx <= pop ? '0 : didx + I_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + P_ONE;
            end
            case ({capture, pop})
                2'b10:   count <= count + C_ONE;
                2'b01:   count <= count - C_ONE;
                default: count <= count;
            endcase
        end
    end

`ifdef SA_DRAIN_STATS_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vcount <= '0;
        end else if (capture) begin
            vcount <= vcount + 16'd1;
        end
    end
`endif

endmodule

// File: doc/sa_result_drain.md
SA_RESULT_DRAIN -- requirements
Module: sa_result_drain

Interface
REQ-001 Parameter ROWS, default 8, number of systolic rows, which equals the number of 32-bit results per vector.
REQ-002 Parameter DEPTH, default 4, number of result vectors buffered; it SHALL be a power of two of at least 2.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rstn  input  1  reset, synchronous and active-low.
REQ-005 routport  input  32 x ROWS (unpacked [0:ROWS-1])  per-row result from SA_CORE.
REQ-006 rvalidport  input  ROWS ([0:ROWS-1])  per-row result-valid from SA_CORE.
REQ-007 outread  output  1  read acknowledge to SA_CORE.
REQ-008 dout  output  32  serialized result word.
REQ-009 didx  output  $clog2(ROWS)  row index of dout.
REQ-010 dlast  output  1  high when didx equals ROWS-1.
REQ-011 dvalid  output  1  dout, didx and dlast are valid.
REQ-012 dready  input  1  downstream accepts the word.

Function
REQ-013 Capture condition: outread==1 and all rvalidport bits are 1; on that edge, all ROWS words SHALL be written as one vector at the write pointer.
REQ-014 outread SHALL equal (rstn==1) AND (buffered vector count < DEPTH), combinationally.
REQ-015 A partial rvalidport (some bits 1, not all) SHALL NOT cause a capture; no state changes.
REQ-016 dvalid SHALL be 1 exactly when count > 0; dout SHALL equal word didx of the head vector.
REQ-017 Latency: a vector captured at edge N SHALL present word 0 with dvalid=1 in the cycle after edge N when the buffer was empty.
REQ-018 On dvalid and dready, didx SHALL increment; at didx==ROWS-1 it SHALL return to 0, the head vector SHALL pop, and the read pointer SHALL advance.
REQ-019 While dvalid==1 and dready==0, dout, didx and dlast SHALL hold stable.
REQ-020 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-021 Simultaneous capture and pop: count SHALL stay unchanged and both pointers SHALL advance.
REQ-022 When full and the last word pops on the same edge, no capture SHALL occur (outread was 0); capture becomes possible on the next edge.
REQ-023 Rows SHALL be emitted in order 0..ROWS-1, and vectors in capture order.

Reset
REQ-024 While rstn==0 at a rising edge, the pointers, count and didx SHALL reset to 0.
REQ-025 During reset and in the cycle after it, outputs SHALL be: dvalid=0, outread=0 during reset, and dlast=0.
REQ-026 Reset mid-stream SHALL discard all buffered vectors and any partially sent vector; the storage contents need not be cleared.

Configuration
REQ-027 Macro SA_DRAIN_STATS_EN, when defined, SHALL add port vcount (output, 16 bits), which counts captured vectors.
REQ-028 vcount SHALL reset to 0, increment by 1 per capture, and wrap from 65535 to 0.
REQ-029 Without SA_DRAIN_STATS_EN, vcount and its counter SHALL NOT exist, and all other behaviour SHALL be identical.

Verification (ROWS=8, DEPTH=4)
REQ-030 Hold rstn=0 for 2 cycles with rvalidport all 1 -> outread=0, dvalid=0, no capture, vcount=0.
REQ-031 One vector routport[r]=16r+1, rvalidport=8'hFF for 1 cycle, dready=1 -> next 8 cycles dout=1,17,...,113; didx=0..7; dlast only at 113; then dvalid=0.
REQ-032 dready=0, 5 vectors offered on consecutive cycles -> 4 captured; outread=0 after the 4th; the 5th is held off; dout stays 1 (vector 0, word 0).
REQ-033 rvalidport=8'hF0 for 3 cycles on an empty buffer -> dvalid stays 0 and vcount stays 0.
REQ-034 Full buffer, last word popping while rvalidport=8'hFF -> no capture that edge, count=3; capture on the following edge, count=4.
REQ-035 rstn=0 for one edge while didx=3 with 2 vectors buffered -> next cycle dvalid=0, didx=0, outread=1.
